// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle controller: instruction layout,
// class encodings, FSM states and ALU op codes.
package cpu_pkg;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [16:0] imm;
  } instr_t;

  localparam logic [2:0] CLS_RR   = 3'b000;
  localparam logic [2:0] CLS_RI   = 3'b001;
  localparam logic [2:0] CLS_BEQZ = 3'b010;
  localparam logic [2:0] CLS_HALT = 3'b011;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  function automatic logic [31:0] sext_imm(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module reg_file #(
  parameter int NREG = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_ra1,
  input  logic [2:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [2:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != 3'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 3'd0) ? 32'd0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == 3'd0) ? 32'd0 : r_regs[i_ra2];

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/WB sequencing around an
// external ALU and instruction memory, with HALT and illegal-class handling.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          NREG     = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        halted,
  output logic        illegal
);

  state_e      r_state;
  state_e      w_next;
  instr_t      r_ir;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic [31:0] r_res;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_imm;
  logic        w_we;

  assign w_imm     = sext_imm(r_ir.imm);
  assign w_we      = (r_state == ST_WB) && ((r_ir.cls == CLS_RR) || (r_ir.cls == CLS_RI));
  assign imem_addr = r_pc;

  reg_file #(.NREG(NREG)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (r_ir.rs1),
    .i_ra2 (r_ir.rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_we),
    .i_wa  (r_ir.rd),
    .i_wd  (r_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      if ((r_state == ST_FETCH) && imem_ack) r_ir <= instr_t'(imem_rdata);
    end
  end

  // Operand and result latches carry data only; the FSM qualifies their use.
  always_ff @(posedge clk) begin
    if (r_state == ST_DECODE) begin
      r_opa <= w_rd1;
      r_opb <= w_rd2;
    end
    if (r_state == ST_EXEC) r_res <= alu_res;
  end

  always_comb begin
    w_next    = r_state;
    w_pc_next = r_pc;
    imem_req  = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_op    = ALU_ADD;
    case (r_state)
      ST_FETCH: begin
        // Request is masked during reset so a reset cycle never shows a fetch.
        imem_req = !rst;
        if (imem_ack) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        case (r_ir.cls)
          CLS_RR, CLS_RI, CLS_BEQZ: w_next = ST_EXEC;
          CLS_HALT:                 w_next = ST_HALT;
          default: begin
            illegal   = !rst;
            w_pc_next = r_pc + PC_STEP;
            w_next    = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: begin
        alu_a  = r_opa;
        alu_b  = (r_ir.cls == CLS_RR) ? r_opb : w_imm;
        alu_op = r_ir.op;
        w_next = ST_WB;
      end
      ST_WB: begin
        if ((r_ir.cls == CLS_BEQZ) && (r_opa == 32'd0))
          w_pc_next = r_pc + {w_imm[29:0], 2'b00};
        else
          w_pc_next = r_pc + PC_STEP;
        w_next = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: w_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: an imem driver feeds directed and random
// instructions, an architectural model predicts each one, a monitor checks.
module tb_cpu_ctrl;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [2:0]  alu_op;
  logic        halted, illegal;

  always #5 clk = ~clk;

  cpu_ctrl #(.PC_RESET(PC_RST), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .halted     (halted),
    .illegal    (illegal)
  );

  // External ALU
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_res = alu_fn(alu_a, alu_b, alu_op);

  // kind: 0 = four-cycle (ALU/BEQZ), 1 = illegal, 2 = halt
  typedef struct {
    logic [31:0] addr;
    int          kind;
    bit          chk_alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_busy = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_regs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input int cls, input int op, input int rd,
                                     input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    w = {cls[2:0], op[2:0], rd[2:0], rs1[2:0], rs2[2:0], imm[16:0]};
    return w;
  endfunction

  task automatic model_reset();
    m_pc = PC_RST;
    for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      got = imem_req;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL fetch_req: imem_req stayed 0, expected 1 within 30 cycles");
    end
  endtask

  // Predict the architectural effect of one instruction, then hand it to the DUT.
  task automatic issue(input logic [31:0] instr, input int max_wait);
    exp_t        e;
    bit          got;
    logic [2:0]  cls, rd;
    logic [31:0] imm, res;
    wait_req(got);
    if (!got) return;
    repeat ($urandom_range(0, max_wait)) begin
      @(posedge clk); #1;
      chk("req_held", {31'd0, imem_req}, 32'd1);
    end
    cls       = instr[31:29];
    rd        = instr[25:23];
    imm       = {{15{instr[16]}}, instr[16:0]};
    e.addr    = m_pc;
    e.kind    = 0;
    e.chk_alu = 1'b0;
    e.a       = m_regs[instr[22:20]];
    e.b       = (cls == 3'd0) ? m_regs[instr[19:17]] : imm;
    e.op      = instr[28:26];
    case (cls)
      3'd0, 3'd1: begin
        e.chk_alu = 1'b1;
        res = alu_fn(e.a, e.b, e.op);
        if (rd != 3'd0) m_regs[rd] = res;
        m_pc = m_pc + 32'd4;
      end
      3'd2:    m_pc = (e.a == 32'd0) ? m_pc + imm * 4 : m_pc + 32'd4;
      3'd3:    e.kind = 2;
      default: begin
        e.kind = 1;
        m_pc   = m_pc + 32'd4;
      end
    endcase
    q.push_back(e);
    imem_rdata = instr;
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(posedge clk); #1;
      idle = (q.size() == 0) && !mon_busy;
    end
    if (!idle) begin
      checks++; errors++;
      $display("FAIL idle: %0d entries still pending, expected 0", q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_alu_idle", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
    chk("rst_req_after", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, PC_RST);
  endtask

  // Monitor: each accepted fetch pops its prediction and follows it through the pipeline.
  initial begin
    exp_t e;
    bit   exp_req = 1'b0;
    bit   exp_noill = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_req) begin
        chk("latency_req", {31'd0, imem_req}, 32'd1);
        exp_req = 1'b0;
      end
      if (exp_noill) begin
        chk("illegal_one_cycle", {31'd0, illegal}, 32'd0);
        exp_noill = 1'b0;
      end
      if (!rst && imem_req && imem_ack) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: fetch at %h, expected none", imem_addr);
        end else begin
          mon_busy = 1'b1;
          e = q.pop_front();
          chk("fetch_addr", imem_addr, e.addr);
          @(negedge clk);
          chk("decode_alu_idle", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
          if (e.kind == 1) begin
            chk("illegal_pulse", {31'd0, illegal}, 32'd1);
            exp_req   = 1'b1;
            exp_noill = 1'b1;
          end else begin
            chk("illegal_quiet", {31'd0, illegal}, 32'd0);
            if (e.kind == 0) begin
              @(negedge clk);
              if (e.chk_alu) begin
                chk("exec_alu_a", alu_a, e.a);
                chk("exec_alu_b", alu_b, e.b);
                chk("exec_alu_op", {29'd0, alu_op}, {29'd0, e.op});
              end
              @(negedge clk);
              chk("wb_alu_idle", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
              chk("wb_req", {31'd0, imem_req}, 32'd0);
              exp_req = 1'b1;
            end else begin
              repeat (20) begin
                @(negedge clk);
                chk("halt_state", {30'd0, halted, imem_req}, 32'd2);
              end
            end
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    bit got;
    int r;
    logic [31:0] instr;
    model_reset();
    do_reset();

    issue(mk(1, 0, 1, 0, 0, 5), 0);    // r1 = 5, next fetch at 4
    issue(mk(1, 0, 2, 0, 0, 3), 0);    // r2 = 3
    issue(mk(2, 0, 0, 0, 0, -2), 0);   // BEQZ r0 at 8 -> 0
    issue(mk(0, 0, 3, 1, 2, 0), 0);    // r3 = r1 + r2
    issue(mk(0, 1, 4, 3, 1, 0), 1);    // reads back r3
    issue(mk(2, 0, 0, 1, 0, -2), 1);   // BEQZ r1 at 8 -> 12
    issue(mk(1, 0, 0, 0, 0, 7), 2);    // write to r0 discarded
    issue(mk(0, 0, 5, 0, 0, 0), 2);    // r0 reads 0
    issue(mk(5, 0, 0, 0, 0, 0), 3);    // illegal class
    issue(mk(2, 0, 0, 0, 0, -7), 0);   // PC 24 -> FFFF_FFFC
    issue(mk(1, 0, 7, 0, 0, 1), 0);    // PC wraps to 0
    issue(mk(0, 2, 6, 7, 1, 0), 0);

    repeat (60) begin
      r     = $urandom_range(0, 6);
      instr = $urandom;
      instr[31:29] = (r < 3) ? r[2:0] : 3'(r + 1);
      issue(instr, 3);
    end
    wait_idle();

    issue(mk(3, 0, 0, 0, 0, 0), 0);
    wait_idle();
    chk("halted_held", {31'd0, halted}, 32'd1);
    do_reset();

    issue(mk(1, 0, 1, 0, 0, 9), 0);
    issue(mk(1, 0, 2, 0, 0, 4), 0);
    wait_req(got);
    if (got) begin
      @(posedge clk); #1;
      chk("midfetch_req", {31'd0, imem_req}, 32'd1);
      chk("midfetch_addr", imem_addr, m_pc);
      rst        = 1'b1;
      imem_rdata = mk(1, 0, 3, 0, 0, 11);
      imem_ack   = 1'b1;
      @(negedge clk);
      chk("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;
      rst      = 1'b0;
      imem_ack = 1'b0;
      model_reset();
      @(negedge clk);
      chk("refetch_addr", imem_addr, PC_RST);
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
    end
    issue(mk(0, 0, 6, 1, 2, 0), 0);    // r1/r2 cleared by reset
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
